softmax_vec_stream_mem: RTL

- Parametrised vector memory with a built-in multi-pass streaming reader.
- Holds NUM lanes of DATAWIDTH-bit values per word, loaded through a write port.
- On start, streams words 0..addr_limit out with a valid/ready handshake, repeated for 1-3 passes. This covers the softmax max, sub0 and sub1 sweeps from one storage array instead of three memory copies.
- Sits between the host/loader and the softmax datapath.

---
 rtl/softmax_pkg.sv | 22 ++
 rtl/softmax_vec_ram.sv | 30 +++
 rtl/softmax_vec_stream_mem.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/softmax_pkg.sv
// Shared parameters, word-width helper and stream FSM encoding for the softmax
// vector memory.
package softmax_pkg;

  localparam int unsigned DEF_DATAWIDTH = 16;
  localparam int unsigned DEF_NUM       = 4;
  localparam int unsigned DEF_ADDRSIZE  = 8;
  localparam int unsigned MAX_PASSES    = 3;

  function automatic int unsigned word_width(input int unsigned dw, input int unsigned num);
    return dw * num;
  endfunction

  localparam int unsigned DEF_W = word_width(DEF_DATAWIDTH, DEF_NUM);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/softmax_vec_ram.sv
// Single-array vector storage: one synchronous write port and one registered
// read port; a same-address read and write returns the old word.
module softmax_vec_ram
  import softmax_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_W,
  parameter int unsigned ADDRSIZE = DEF_ADDRSIZE
) (
  input  logic                clk_i,
  input  logic                wr_en_i,
  input  logic [ADDRSIZE-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]    wr_data_i,
  input  logic                rd_en_i,
  input  logic [ADDRSIZE-1:0] rd_addr_i,
  output logic [WIDTH-1:0]    rd_data_o
);

  localparam int unsigned DEPTH = 2 ** ADDRSIZE;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/softmax_vec_stream_mem.sv
// Vector memory with a multi-pass streaming reader: words 0..addr_limit are
// replayed 1-3 times through a 2-entry output FIFO with valid/ready handshake.
module softmax_vec_stream_mem
  import softmax_pkg::*;
#(
  parameter int unsigned DATAWIDTH = DEF_DATAWIDTH,
  parameter int unsigned NUM       = DEF_NUM,
  parameter int unsigned ADDRSIZE  = DEF_ADDRSIZE
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [ADDRSIZE-1:0]       wr_addr,
  input  logic [DATAWIDTH*NUM-1:0]  wr_data,
  input  logic                      start,
  input  logic [ADDRSIZE-1:0]       addr_limit,
  input  logic [1:0]                num_passes,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATAWIDTH*NUM-1:0]  out_data,
  output logic [ADDRSIZE-1:0]       out_addr,
  output logic [1:0]                out_pass,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned W = word_width(DATAWIDTH, NUM);

  state_e              state_q, state_d;
  logic [ADDRSIZE-1:0] rd_addr_q, rd_addr_d;
  logic [1:0]          pass_q, pass_d;
  logic [ADDRSIZE-1:0] limit_q, limit_d;
  logic [1:0]          npass_q, npass_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                inflight_q;
  logic [ADDRSIZE-1:0] infl_addr_q;
  logic [1:0]          infl_pass_q;
  logic                infl_last_q;

  logic [W-1:0]        fifo_data_q [2];
  logic [ADDRSIZE-1:0] fifo_addr_q [2];
  logic [1:0]          fifo_pass_q [2];
  logic                fifo_last_q [2];
  logic                wr_ptr_q, rd_ptr_q;
  logic [1:0]          count_q;

  logic                issue, issue_last, push, pop;
  logic [ADDRSIZE-1:0] issue_addr, cur_limit;
  logic [1:0]          issue_pass, cur_npass, npass_in;
  logic [2:0]          occ;
  logic [W-1:0]        ram_rdata;

  softmax_vec_ram #(
    .WIDTH    (W),
    .ADDRSIZE (ADDRSIZE)
  ) u_ram (
    .clk_i     (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_en_i   (issue),
    .rd_addr_i (issue_addr),
    .rd_data_o (ram_rdata)
  );

  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid && out_ready;
  assign push      = inflight_q;
  assign npass_in  = (num_passes == 2'd0) ? 2'd1 : num_passes;
  // Credit counts a same-cycle pop as freed space, otherwise the FIFO
  // starves every other cycle and 1 beat/cycle is never reached.
  assign occ = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    pass_d     = pass_q;
    limit_d    = limit_q;
    npass_d    = npass_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    issue      = 1'b0;
    issue_last = 1'b0;
    issue_addr = rd_addr_q;
    issue_pass = pass_q;
    cur_limit  = limit_q;
    cur_npass  = npass_q;

    unique case (state_q)
      ST_IDLE: begin
        // The first read goes out with the accepting start so that data
        // reaches the output two cycles later.
        if (start && !done_q) begin
          state_d    = ST_READ;
          limit_d    = addr_limit;
          npass_d    = npass_in;
          busy_d     = 1'b1;
          issue      = 1'b1;
          issue_addr = '0;
          issue_pass = '0;
          cur_limit  = addr_limit;
          cur_npass  = npass_in;
        end
      end
      ST_READ: begin
        issue = (occ < 3'd2);
      end
      ST_DRAIN: begin
        if ((count_q == 2'd1) && !inflight_q && pop) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (issue) begin
      issue_last = (issue_addr == cur_limit);
      if (issue_last) begin
        rd_addr_d = '0;
        pass_d    = issue_pass + 2'd1;
        if (issue_pass == cur_npass - 2'd1) state_d = ST_DRAIN;
      end else begin
        rd_addr_d = issue_addr + 1'b1;
        pass_d    = issue_pass;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rd_addr_q   <= '0;
      pass_q      <= '0;
      limit_q     <= '0;
      npass_q     <= 2'd1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      inflight_q  <= 1'b0;
      infl_addr_q <= '0;
      infl_pass_q <= '0;
      infl_last_q <= 1'b0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_addr_q[i] <= '0;
        fifo_pass_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      pass_q     <= pass_d;
      limit_q    <= limit_d;
      npass_q    <= npass_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      inflight_q <= issue;
      if (issue) begin
        infl_addr_q <= issue_addr;
        infl_pass_q <= issue_pass;
        infl_last_q <= issue_last;
      end
      if (push) begin
        fifo_data_q[wr_ptr_q] <= ram_rdata;
        fifo_addr_q[wr_ptr_q] <= infl_addr_q;
        fifo_pass_q[wr_ptr_q] <= infl_pass_q;
        fifo_last_q[wr_ptr_q] <= infl_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign out_data = fifo_data_q[rd_ptr_q];
  assign out_addr = fifo_addr_q[rd_ptr_q];
  assign out_pass = fifo_pass_q[rd_ptr_q];
  assign out_last = fifo_last_q[rd_ptr_q];
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
